lsu_ctrl: RTL and testbench

Multi-cycle load/store controller for the RV32I core. It sits directly downstream of the ALU: it takes the ALU result as the effective address, runs a request/acknowledge transaction with data memory and formats the data. Store data is lane-replicated with byte strobes. Load data is lane-selected and sign- or zero-extended. While a transaction is in flight it stalls the core through `busy`.

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/lsu_align.sv | 80 ++++++++
 rtl/lsu_ctrl.sv | 144 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: funct3 width codes,
// FSM state encoding and byte-strobe patterns.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] STRB_B    = 4'b0001;
  localparam logic [3:0] STRB_H_LO = 4'b0011;
  localparam logic [3:0] STRB_H_HI = 4'b1100;
  localparam logic [3:0] STRB_W    = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational data path of the LSU: request legality, store lane
// replication with strobes, and load lane extraction with extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_mem_rdata,
  output logic        o_legal,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_mem_rdata[{i_ld_off, 3'b000} +: 8];
  assign w_half = i_mem_rdata[{i_ld_off[1], 4'b0000} +: 16];

  always_comb begin
    o_legal = 1'b0;
    if (i_we) begin
      case (i_funct3)
        F3_B:    o_legal = 1'b1;
        F3_H:    o_legal = ~i_addr_lo[0];
        F3_W:    o_legal = (i_addr_lo == 2'b00);
        default: o_legal = 1'b0;
      endcase
    end else begin
      case (i_funct3)
        F3_B, F3_BU: o_legal = 1'b1;
        F3_H, F3_HU: o_legal = ~i_addr_lo[0];
        F3_W:        o_legal = (i_addr_lo == 2'b00);
        default:     o_legal = 1'b0;
      endcase
    end
  end

  // Store data is replicated into every lane so the strobes alone pick the bytes.
  always_comb begin
    o_wstrb = 4'b0000;
    o_wdata = 32'h0;
    case (i_funct3)
      F3_B: begin
        o_wstrb = STRB_B << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      F3_H: begin
        o_wstrb = i_addr_lo[1] ? STRB_H_HI : STRB_H_LO;
        o_wdata = {2{i_wdata[15:0]}};
      end
      F3_W: begin
        o_wstrb = STRB_W;
        o_wdata = i_wdata;
      end
      default: begin
        o_wstrb = 4'b0000;
        o_wdata = 32'h0;
      end
    endcase
  end

  always_comb begin
    o_ld_data = 32'h0;
    case (i_ld_funct3)
      F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
      F3_W:    o_ld_data = i_mem_rdata;
      F3_BU:   o_ld_data = {24'h0, w_byte};
      F3_HU:   o_ld_data = {16'h0, w_half};
      default: o_ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts a request in IDLE, holds a req/ack memory
// transaction in REQ with a timeout, and reports completion for one cycle in DONE.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_t  r_state, w_next_state;
  logic [CW-1:0] r_cnt;
  logic        r_busy, r_done, r_err, r_mem_req, r_mem_we;
  logic [31:0] r_rdata, r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_wstrb;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;

  logic        w_legal;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata, w_ld_data;
  logic        w_expired;

  lsu_align u_align (
    .i_we        (req_we),
    .i_funct3    (funct3),
    .i_addr_lo   (addr[1:0]),
    .i_wdata     (wdata),
    .i_ld_funct3 (r_funct3),
    .i_ld_off    (r_off),
    .i_mem_rdata (mem_rdata),
    .o_legal     (w_legal),
    .o_wstrb     (w_wstrb),
    .o_wdata     (w_wdata),
    .o_ld_data   (w_ld_data)
  );

  assign w_expired = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next_state = w_legal ? REQ : DONE;
      REQ:     if (mem_ack || w_expired) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Ack is tested before expiry so a late ack in the final cycle still succeeds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= 32'h0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_wstrb <= 4'b0000;
      r_mem_wdata <= 32'h0;
      r_funct3    <= 3'b000;
      r_off       <= 2'b00;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            if (w_legal) begin
              r_busy      <= 1'b1;
              r_mem_req   <= 1'b1;
              r_mem_we    <= req_we;
              r_mem_addr  <= {addr[31:2], 2'b00};
              r_mem_wstrb <= req_we ? w_wstrb : 4'b0000;
              r_mem_wdata <= req_we ? w_wdata : 32'h0;
              r_funct3    <= funct3;
              r_off       <= addr[1:0];
              r_cnt       <= '0;
            end else begin
              r_done  <= 1'b1;
              r_err   <= 1'b1;
              r_rdata <= 32'h0;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            r_busy    <= 1'b0;
            r_mem_req <= 1'b0;
            r_done    <= 1'b1;
            r_rdata   <= r_mem_we ? 32'h0 : w_ld_data;
          end else if (w_expired) begin
            r_busy    <= 1'b0;
            r_mem_req <= 1'b0;
            r_done    <= 1'b1;
            r_err     <= 1'b1;
            r_rdata   <= 32'h0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wstrb = r_mem_wstrb;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: a table of directed transactions with fixed expected
// values, random transactions checked against an arithmetic model, and reset/idle corner cases.
module tb_lsu_ctrl;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rstN;
  logic        reqValid, reqWe, memAck;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, memRdata;
  logic        busy, done, err, memReq, memWe;
  logic [31:0] rdata, memAddr, memWdata;
  logic [3:0]  memWstrb;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          ackDelay;
    logic        expLegal;
    logic [3:0]  expStrb;
    logic [31:0] expWdata;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs[$];

  lsu_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .req_valid (reqValid),
    .req_we    (reqWe),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_req   (memReq),
    .mem_we    (memWe),
    .mem_addr  (memAddr),
    .mem_wstrb (memWstrb),
    .mem_wdata (memWdata),
    .mem_ack   (memAck),
    .mem_rdata (memRdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: access size, alignment and lane positions from plain arithmetic.
  function automatic int sizeBytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic modelLegal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    bit ok;
    if (we) ok = (f3 <= 3'd2);
    else    ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    return ok && ((a % sizeBytes(f3)) == 0);
  endfunction

  function automatic logic [3:0] modelStrb(input logic [2:0] f3, input logic [31:0] a);
    int n = sizeBytes(f3);
    logic [3:0] mask = 4'((1 << n) - 1);
    return mask << (a % 4);
  endfunction

  function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] wd);
    case (sizeBytes(f3))
      1:       return {24'h0, wd[7:0]} * 32'h01010101;
      2:       return {16'h0, wd[15:0]} * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] modelRdata(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] mrd);
    int n = sizeBytes(f3);
    logic [31:0] mask, val;
    if (n >= 4) return mrd;
    mask = (32'h1 << (8 * n)) - 32'h1;
    val  = (mrd >> (8 * (a % 4))) & mask;
    if (!f3[2] && val[8*n-1]) val = val | ~mask;
    return val;
  endfunction

  task automatic addVec(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mrd,
                        input int ackDelay, input logic expLegal, input logic [3:0] expStrb,
                        input logic [31:0] expWdata, input logic [31:0] expRdata);
    vec_t v;
    v.name = name; v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.mrdata = mrd;
    v.ackDelay = ackDelay; v.expLegal = expLegal; v.expStrb = expStrb;
    v.expWdata = expWdata; v.expRdata = expRdata;
    vecs.push_back(v);
  endtask

  // One full transaction; ackDelay is the REQ cycle index carrying mem_ack (-1 = never).
  task automatic applyStimulus(input vec_t v);
    int reqCycles;
    bit acked;
    reqValid = 1'b1;
    reqWe    = v.we;
    funct3   = v.f3;
    addr     = v.addr;
    wdata    = v.wdata;
    memAck   = 1'b0;
    step();
    if (!v.expLegal) begin
      checkOutput({v.name, "/illegalDone"}, 32'(done), 32'd1);
      checkOutput({v.name, "/illegalErr"}, 32'(err), 32'd1);
      checkOutput({v.name, "/illegalRdata"}, rdata, 32'h0);
      checkOutput({v.name, "/illegalMemReq"}, 32'(memReq), 32'd0);
      checkOutput({v.name, "/illegalBusy"}, 32'(busy), 32'd0);
    end else begin
      checkOutput({v.name, "/busy"}, 32'(busy), 32'd1);
      checkOutput({v.name, "/memReq"}, 32'(memReq), 32'd1);
      checkOutput({v.name, "/memWe"}, 32'(memWe), 32'(v.we));
      checkOutput({v.name, "/memAddr"}, memAddr, {v.addr[31:2], 2'b00});
      checkOutput({v.name, "/memWstrb"}, 32'(memWstrb), 32'(v.expStrb));
      if (v.we) checkOutput({v.name, "/memWdata"}, memWdata, v.expWdata);
      reqCycles = 0;
      acked = 1'b0;
      for (int k = 0; k < TIMEOUT; k++) begin
        if (memReq) reqCycles++;
        if (k == v.ackDelay || k == TIMEOUT - 1)
          checkOutput({v.name, "/addrHold"}, memAddr, {v.addr[31:2], 2'b00});
        if (k == v.ackDelay) begin
          memAck   = 1'b1;
          memRdata = v.mrdata;
        end
        step();
        memAck   = 1'b0;
        memRdata = $urandom;
        if (k == v.ackDelay) begin
          acked = 1'b1;
          break;
        end
      end
      checkOutput({v.name, "/done"}, 32'(done), 32'd1);
      checkOutput({v.name, "/err"}, 32'(err), acked ? 32'd0 : 32'd1);
      checkOutput({v.name, "/memReqDrop"}, 32'(memReq), 32'd0);
      if (!acked) begin
        checkOutput({v.name, "/timeoutRdata"}, rdata, 32'h0);
        checkOutput({v.name, "/timeoutReqCycles"}, 32'(reqCycles), 32'(TIMEOUT));
      end else if (!v.we) begin
        checkOutput({v.name, "/rdata"}, rdata, v.expRdata);
      end
    end
    reqValid = 1'b0;
    step();
    checkOutput({v.name, "/doneLow"}, 32'(done), 32'd0);
    checkOutput({v.name, "/errLow"}, 32'(err), 32'd0);
  endtask

  initial begin
    vec_t rv;
    rstN = 1'b0; reqValid = 1'b0; reqWe = 1'b0; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; memAck = 1'b0; memRdata = 32'h0;

    #23;
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetDone", 32'(done), 32'd0);
    checkOutput("resetMemReq", 32'(memReq), 32'd0);
    checkOutput("resetRdata", rdata, 32'h0);
    checkOutput("resetMemAddr", memAddr, 32'h0);
    checkOutput("resetMemWstrb", 32'(memWstrb), 32'd0);
    rstN = 1'b1;
    step();

    addVec("sw",      1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        0,  1'b1, 4'b1111, 32'hDEADBEEF, 32'h0);
    addVec("sb",      1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        1,  1'b1, 4'b1000, 32'hA5A5A5A5, 32'h0);
    addVec("lb2",     1'b0, 3'b000, 32'h002, 32'h0,        32'h80FF7F01, 0,  1'b1, 4'b0000, 32'h0, 32'hFFFFFFFF);
    addVec("lbu2",    1'b0, 3'b100, 32'h002, 32'h0,        32'h80FF7F01, 1,  1'b1, 4'b0000, 32'h0, 32'h000000FF);
    addVec("lb0",     1'b0, 3'b000, 32'h000, 32'h0,        32'h80FF7F01, 0,  1'b1, 4'b0000, 32'h0, 32'h00000001);
    addVec("lh2",     1'b0, 3'b001, 32'h002, 32'h0,        32'h80FF7F01, 2,  1'b1, 4'b0000, 32'h0, 32'hFFFF80FF);
    addVec("lhu2",    1'b0, 3'b101, 32'h002, 32'h0,        32'h80FF7F01, 0,  1'b1, 4'b0000, 32'h0, 32'h000080FF);
    addVec("lwMis",   1'b0, 3'b010, 32'h101, 32'h0,        32'h0,        0,  1'b0, 4'b0000, 32'h0, 32'h0);
    addVec("sf3bad",  1'b1, 3'b011, 32'h200, 32'h12345678, 32'h0,        0,  1'b0, 4'b0000, 32'h0, 32'h0);
    addVec("lwTmo",   1'b0, 3'b010, 32'h040, 32'h0,        32'h0,        -1, 1'b1, 4'b0000, 32'h0, 32'h0);
    addVec("lwLate",  1'b0, 3'b010, 32'h044, 32'h0,        32'h13572468, 3,  1'b1, 4'b0000, 32'h0, 32'h13572468);
    addVec("sh6",     1'b1, 3'b001, 32'h006, 32'h1234ABCD, 32'h0,        1,  1'b1, 4'b1100, 32'hABCDABCD, 32'h0);
    addVec("lw8",     1'b0, 3'b010, 32'h008, 32'h0,        32'h12345678, 2,  1'b1, 4'b0000, 32'h0, 32'h12345678);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // An ack while idle must not start or complete anything.
    memAck = 1'b1;
    step();
    memAck = 1'b0;
    checkOutput("idleAckDone", 32'(done), 32'd0);
    checkOutput("idleAckBusy", 32'(busy), 32'd0);

    // Reset during REQ: mem_req falls without a clock edge and no done follows.
    reqValid = 1'b1; reqWe = 1'b0; funct3 = 3'b010; addr = 32'h300;
    step();
    checkOutput("rstMidReqUp", 32'(memReq), 32'd1);
    step();
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("rstMidMemReq", 32'(memReq), 32'd0);
    checkOutput("rstMidBusy", 32'(busy), 32'd0);
    reqValid = 1'b0;
    #2;
    rstN = 1'b1;
    memAck = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      memAck = 1'b0;
      checkOutput("rstNoDone", 32'(done), 32'd0);
    end

    for (int n = 0; n < 40; n++) begin
      rv.name     = "rand";
      rv.we       = 1'($urandom_range(0, 1));
      rv.f3       = 3'($urandom_range(0, 7));
      rv.addr     = $urandom;
      rv.wdata    = $urandom;
      rv.mrdata   = $urandom;
      rv.ackDelay = $urandom_range(0, TIMEOUT + 1);
      rv.expLegal = modelLegal(rv.we, rv.f3, rv.addr);
      rv.expStrb  = rv.we ? modelStrb(rv.f3, rv.addr) : 4'b0000;
      rv.expWdata = modelWdata(rv.f3, rv.wdata);
      rv.expRdata = modelRdata(rv.f3, rv.addr, rv.mrdata);
      applyStimulus(rv);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
